delay_tap_sequencer: RTL and testbench
======================================

# delay_tap_sequencer

Controller for the multi-tap delay-line datapath: owns tap selection, tracks fill state after reset, and produces a registered, qualified output sample. Sits between the four free-running delay lines (30/45/60/90 stages) and the chip outputs. Replaces the raw combinational tap mux with a req/ready handshake. Every tap change passes through a short hold interval, and no sample is flagged valid until the selected line has filled.

## Interface
Parameters:
- WIDTH, 8, sample width
- HOLD_CYCLES, 2, cycles the output is frozen during a tap switch (legal range 1..15)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block enable; low forces output idle
- taps_in  in  4*WIDTH  tap samples; bits [WIDTH*k +: WIDTH] come from tap k
- req_valid  in  1  tap-change request
- req_tap  in  2  requested tap index: 0=30, 1=45, 2=60, 3=90 stages
- req_ready  out  1  request accepted when req_valid && req_ready
- tap_sel  out  2  currently active tap index
- data_out  out  WIDTH  registered output sample
- data_valid  out  1  data_out holds a valid delayed sample
- busy  out  1  high in HOLD

## Operation
- Reset values: state=FILL, tap_sel=0, fill_cnt=0, hold_cnt=0, data_out=0, data_valid=0, req_ready=0, busy=0.
- fill_cnt: 7-bit counter. Increments every clock after reset, regardless of enable, because the lines free-run. Saturates at MAX_DEPTH=90.
- depth(k) comes from a package constant: {30,45,60,90}. A tap is "filled" when fill_cnt >= depth(tap_sel).
- States:
  - IDLE: entered from any state when enable=0. data_out=0, data_valid=0, req_ready=0. On enable=1, go to FILL.
  - FILL: data_out=0, data_valid=0, req_ready=1. Go to RUN on the first cycle the tap is filled.
  - RUN: data_out<=taps_in[tap_sel], data_valid=1, req_ready=1.
  - HOLD: data_out frozen at its last value, data_valid=0, req_ready=0, busy=1. Runs for HOLD_CYCLES cycles. Then tap_sel<=pending, and the next state is RUN if the new tap is filled, else FILL.
- Request accepted in FILL or RUN:
  - req_tap==tap_sel: accepted and consumed; state unchanged; no output disturbance.
  - Otherwise: latch pending=req_tap, set hold_cnt=HOLD_CYCLES-1, enter HOLD.
- enable falling during HOLD: the pending tap is applied immediately (tap_sel<=pending), then go to IDLE.
- Simultaneous enable=0 and an accepted-looking request: enable wins; the request is not accepted because req_ready is 0 in the next state logic.
- Reset mid-operation: all state returns to reset values at once, and fill restarts from 0.

## Timing
- Output latency: data_out reflects taps_in[tap_sel] from the previous clock (1 cycle).
- First valid after reset, tap 0: data_valid rises on the cycle after fill_cnt reaches 30.
- Request accept to new-tap data: HOLD_CYCLES cycles of HOLD, plus 1 cycle register latency, when the new tap is already filled.
- req_ready is registered-state driven; there is no combinational path from req_valid to req_ready.

## Configuration
- DELAY_SEQ_STATUS_EN:
  - Defined: adds output switch_count (8 bits), an 8-bit counter of completed tap switches. It increments on each HOLD exit, including the enable-abort path. It saturates at 255 and resets to 0.
  - Undefined: the port and counter are absent.

## Structure
- Shared package delay_line_pkg holds:
  - TAP_COUNT=4 and MAX_DEPTH=90
  - the depth lookup constant array {30,45,60,90}
  - the state enum type (IDLE, FILL, RUN, HOLD)
- The tap mux is a natural single sub-module, delay_tap_mux (combinational select of taps_in by index). The FSM, counters and output register stay in the top.

## Test plan
- Reset, enable=1, tap 0, taps_in tap0=8'hA5 constant → data_valid=0 for the first 30 cycles, then 1; data_out=8'hA5.
- At cycle 40, request tap 3 → req_ready low for 2 cycles, data_out held at 8'hA5, data_valid=0; then FILL until fill_cnt=90; RUN with tap3 data.
- After full fill, request tap 1 → HOLD 2 cycles, then RUN directly; tap_sel=1; data_valid back high 3 cycles after accept.
- Request equal to current tap → accepted in one cycle; busy stays 0; data_valid uninterrupted.
- Drop enable during HOLD → next cycle IDLE, data_out=0, tap_sel=pending. Re-enable → RUN the cycle after FILL, given filled.
- With DELAY_SEQ_STATUS_EN, perform 300 alternating switches → switch_count=255. Assert reset mid-HOLD → all outputs 0 immediately and switch_count=0.

Source files
------------

// File: rtl/delay_tap_sequencer_pkg.sv
// Shared delay-line definitions: tap count, line depths, sequencer state type.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package delay_line_pkg;

  localparam int TAP_COUNT = 4;
  localparam int MAX_DEPTH = 90;
  localparam int FILL_W    = 7;

  typedef logic [FILL_W-1:0] fill_t;
  typedef logic [1:0]        tap_t;

  // Stage count of each free-running line, indexed by tap number.
  localparam fill_t TAP_DEPTH [TAP_COUNT] = '{7'd30, 7'd45, 7'd60, 7'd90};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic fill_t tap_depth(input tap_t k);
    return TAP_DEPTH[k];
  endfunction

endpackage

// File: rtl/delay_tap_sequencer_if.sv
// Tap-select request handshake plus tap sample bus and qualified output sample.
// Latency: n/a (signal bundle only).
// Backpressure: requests stall while req_ready is low. Optional switch_count under DELAY_SEQ_STATUS_EN.
interface delay_tap_sequencer_if #(
  parameter int WIDTH = 8
);
  import delay_line_pkg::*;

  logic [4*WIDTH-1:0] taps_in;
  logic               req_valid;
  tap_t               req_tap;
  logic               req_ready;
  tap_t               tap_sel;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid;
  logic               busy;
`ifdef DELAY_SEQ_STATUS_EN
  logic [7:0]         switch_count;
`endif

`ifdef DELAY_SEQ_STATUS_EN
  modport master (
    output taps_in, req_valid, req_tap,
    input  req_ready, tap_sel, data_out, data_valid, busy, switch_count
  );
  modport slave (
    input  taps_in, req_valid, req_tap,
    output req_ready, tap_sel, data_out, data_valid, busy, switch_count
  );
`else
  modport master (
    output taps_in, req_valid, req_tap,
    input  req_ready, tap_sel, data_out, data_valid, busy
  );
  modport slave (
    input  taps_in, req_valid, req_tap,
    output req_ready, tap_sel, data_out, data_valid, busy
  );
`endif

endinterface

// File: rtl/delay_tap_sequencer_mux.sv
// Combinational select of one tap sample out of the packed tap bus.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module delay_tap_mux
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [4*WIDTH-1:0] taps_in,
  input  tap_t               sel,
  output logic [WIDTH-1:0]   sample
);

  // Pick tap k from bits [WIDTH*k +: WIDTH].
  always_comb begin
    sample = taps_in[0 +: WIDTH];
    case (sel)
      2'd0: sample = taps_in[0*WIDTH +: WIDTH];
      2'd1: sample = taps_in[1*WIDTH +: WIDTH];
      2'd2: sample = taps_in[2*WIDTH +: WIDTH];
      2'd3: sample = taps_in[3*WIDTH +: WIDTH];
      default: sample = taps_in[0 +: WIDTH];
    endcase
  end

endmodule

// File: rtl/delay_tap_sequencer.sv
// Tap-select sequencer: fill tracking, hold-on-switch, registered qualified output sample.
// Latency: 1 cycle taps_in -> data_out; tap switch costs HOLD_CYCLES + 1 when the new line is filled.
// Backpressure: req_ready is low in IDLE/HOLD; it is a flop, never a comb function of req_valid.
// Optional: DELAY_SEQ_STATUS_EN adds switch_count on the interface.
module delay_tap_sequencer
  import delay_line_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  enable,
  delay_tap_sequencer_if.slave bus
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
  localparam fill_t      FILL_MAX  = fill_t'(MAX_DEPTH);

  state_t           state;
  state_t           next_state;
  tap_t             tap_sel_q;
  tap_t             pending_q;
  fill_t            fill_cnt;
  logic [3:0]       hold_cnt;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             req_ready_q;
  logic             busy_q;
  logic [WIDTH-1:0] tap_sample;

  logic             accept;
  logic             switch_req;
  logic             hold_done;
  logic             hold_exit;
  logic             filled_cur;
  logic             filled_pend;
  logic             ready_d;
  logic             busy_d;
  logic             load_run;
  logic             clear_data;

  delay_tap_mux #(.WIDTH(WIDTH)) u_mux (
    .taps_in (bus.taps_in),
    .sel     (tap_sel_q),
    .sample  (tap_sample)
  );

  // Handshake and fill qualifiers; enable low blocks acceptance outright.
  always_comb begin
    accept      = bus.req_valid && req_ready_q && enable;
    switch_req  = accept && (bus.req_tap != tap_sel_q);
    hold_done   = (hold_cnt == 4'd0);
    hold_exit   = (state == HOLD) && (!enable || hold_done);
    filled_cur  = (fill_cnt >= tap_depth(tap_sel_q));
    filled_pend = (fill_cnt >= tap_depth(pending_q));
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= next_state;
  end

  // Next state: enable low overrides everything; a switch beats the fill-complete move.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = FILL;
        FILL: begin
          if (switch_req)      next_state = HOLD;
          else if (filled_cur) next_state = RUN;
        end
        RUN: begin
          if (switch_req) next_state = HOLD;
        end
        HOLD: begin
          if (hold_done) next_state = filled_pend ? RUN : FILL;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode from the next state so the flops below line up with the state register.
  always_comb begin
    ready_d    = (next_state == FILL) || (next_state == RUN);
    busy_d     = (next_state == HOLD);
    clear_data = (next_state == IDLE) || (next_state == FILL);
    // Coming out of HOLD the sample stays frozen one more cycle; the new tap is captured next edge.
    load_run   = (next_state == RUN) && ((state == RUN) || (state == FILL));
  end

  // Tap selection, pending latch and hold countdown; an aborted hold still applies the pending tap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tap_sel_q <= 2'd0;
      pending_q <= 2'd0;
      hold_cnt  <= 4'd0;
    end else begin
      if (switch_req) begin
        pending_q <= bus.req_tap;
        hold_cnt  <= HOLD_INIT;
      end else if ((state == HOLD) && !hold_done) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (hold_exit) tap_sel_q <= pending_q;
    end
  end

  // Fill tracker: the lines free-run, so this counts regardless of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     fill_cnt <= '0;
    else if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 7'd1;
  end

  // Registered outputs: sample, its qualifier, and the handshake/busy flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q <= ready_d;
      busy_q      <= busy_d;
      if (clear_data) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else if (load_run) begin
        data_out_q   <= tap_sample;
        data_valid_q <= 1'b1;
      end else begin
        data_valid_q <= 1'b0;
      end
    end
  end

`ifdef DELAY_SEQ_STATUS_EN
  logic [7:0] switch_count_q;

  // Completed-switch counter, saturating; aborted holds count as completed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  switch_count_q <= 8'd0;
    else if (hold_exit && switch_count_q != 8'hFF) switch_count_q <= switch_count_q + 8'd1;
  end

  assign bus.switch_count = switch_count_q;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.tap_sel    = tap_sel_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_delay_tap_sequencer.sv
// Directed plus random stimulus against a behavioural model of the tap sequencer.
// Latency: n/a.
// Backpressure: requests only count when the model's ready flag is set.
module tb_delay_tap_sequencer;

  localparam int WIDTH = 8;
  localparam int HOLD  = 2;
  localparam logic [31:0] TAPS_FIX = {8'h3C, 8'h96, 8'h5A, 8'hA5};

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;
  localparam int M_HOLD = 3;

  logic clock = 1'b0;
  logic reset;
  logic enable;

  delay_tap_sequencer_if #(.WIDTH(WIDTH)) bus();

  delay_tap_sequencer #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: mode, active/pending tap, cycles since reset (capped), hold cycles left.
  int   depth [4] = '{30, 45, 60, 90};
  int   m_mode, m_tap, m_pend, m_fill, m_hold_left, m_sw;
  int   m_dout;
  bit   m_dvld, m_rdy, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_FILL; m_tap = 0; m_pend = 0; m_fill = 0; m_hold_left = 0; m_sw = 0;
    m_dout = 0; m_dvld = 0; m_rdy = 0; m_busy = 0;
  endtask

  task automatic finish_switch(input int new_tap);
    m_tap = new_tap;
    if (m_sw < 255) m_sw++;
  endtask

  task automatic model_step(input bit en, input bit rv, input int rt, input logic [31:0] taps);
    int  om, otap, ofill;
    bit  acc;
    om = m_mode; otap = m_tap; ofill = m_fill;
    acc = en && rv && m_rdy;
    if (!en) begin
      if (om == M_HOLD) finish_switch(m_pend);
      m_mode = M_IDLE;
    end else begin
      case (om)
        M_IDLE: m_mode = M_FILL;
        M_FILL, M_RUN: begin
          if (acc && rt != otap) begin
            m_pend = rt; m_hold_left = HOLD; m_mode = M_HOLD;
          end else if (om == M_FILL && ofill >= depth[otap]) begin
            m_mode = M_RUN;
          end
        end
        default: begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            finish_switch(m_pend);
            m_mode = (ofill >= depth[m_pend]) ? M_RUN : M_FILL;
          end
        end
      endcase
    end
    if (m_mode == M_IDLE || m_mode == M_FILL) begin
      m_dout = 0; m_dvld = 0;
    end else if (m_mode == M_RUN && (om == M_RUN || om == M_FILL)) begin
      m_dout = int'(taps[otap*8 +: 8]); m_dvld = 1;
    end else begin
      m_dvld = 0;
    end
    m_rdy  = (m_mode == M_FILL || m_mode == M_RUN);
    m_busy = (m_mode == M_HOLD);
    if (m_fill < 90) m_fill++;
  endtask

  task automatic check_all();
    chk("data_out",   bus.data_out,   m_dout);
    chk("data_valid", bus.data_valid, m_dvld);
    chk("req_ready",  bus.req_ready,  m_rdy);
    chk("busy",       bus.busy,       m_busy);
    chk("tap_sel",    bus.tap_sel,    m_tap);
`ifdef DELAY_SEQ_STATUS_EN
    chk("switch_count", bus.switch_count, m_sw);
`endif
  endtask

  task automatic step(input bit en, input bit rv, input logic [1:0] rt, input logic [31:0] taps);
    enable = en; bus.req_valid = rv; bus.req_tap = rt; bus.taps_in = taps;
    @(posedge clock);
    model_step(en, rv, int'(rt), taps);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"},   bus.data_out,   0);
    chk({tag, "_data_valid"}, bus.data_valid, 0);
    chk({tag, "_req_ready"},  bus.req_ready,  0);
    chk({tag, "_busy"},       bus.busy,       0);
    chk({tag, "_tap_sel"},    bus.tap_sel,    0);
`ifdef DELAY_SEQ_STATUS_EN
    chk({tag, "_switch_count"}, bus.switch_count, 0);
`endif
  endtask

  initial begin
    int guard;
    reset = 1'b1; enable = 1'b1;
    bus.req_valid = 1'b0; bus.req_tap = 2'd0; bus.taps_in = TAPS_FIX;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    check_reset_outputs("reset");
    reset = 1'b0; cyc = 0;

    // Fill of tap 0: nothing valid until the 30-stage line has filled.
    for (int i = 0; i < 30; i++) step(1, 0, 2'd0, TAPS_FIX);
    chk("fill30_valid", bus.data_valid, 0);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("first_valid", bus.data_valid, 1);
    chk("first_data",  bus.data_out,   32'hA5);

    // Switch to the unfilled 90-stage tap at cycle 40.
    while (cyc < 39) step(1, 0, 2'd0, TAPS_FIX);
    step(1, 1, 2'd3, TAPS_FIX);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("hold_busy",  bus.busy,       1);
    chk("hold_data",  bus.data_out,   32'hA5);
    chk("hold_valid", bus.data_valid, 0);
    chk("hold_ready", bus.req_ready,  0);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("tap3_sel", bus.tap_sel, 3);
    while (cyc < 91) step(1, 0, 2'd0, TAPS_FIX);
    chk("tap3_valid", bus.data_valid, 1);
    chk("tap3_data",  bus.data_out,   32'h3C);

    // Switch to a filled tap: valid returns three cycles after accept.
    step(1, 1, 2'd1, TAPS_FIX);
    step(1, 0, 2'd0, TAPS_FIX);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("tap1_sel",     bus.tap_sel,    1);
    chk("tap1_novalid", bus.data_valid, 0);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("tap1_valid", bus.data_valid, 1);
    chk("tap1_data",  bus.data_out,   32'h5A);

    // Same-tap request is consumed without disturbance.
    step(1, 1, 2'd1, TAPS_FIX);
    chk("same_busy",  bus.busy,       0);
    chk("same_valid", bus.data_valid, 1);

    // Enable drop during hold applies the pending tap and idles.
    step(1, 1, 2'd2, TAPS_FIX);
    step(0, 0, 2'd0, TAPS_FIX);
    chk("abort_tap",   bus.tap_sel,    2);
    chk("abort_data",  bus.data_out,   0);
    chk("abort_valid", bus.data_valid, 0);
    step(1, 0, 2'd0, TAPS_FIX);
    step(1, 0, 2'd0, TAPS_FIX);
    chk("reen_valid", bus.data_valid, 1);
    chk("reen_data",  bus.data_out,   32'h96);

    // Enable low together with a request: request is dropped.
    step(0, 1, 2'd3, TAPS_FIX);
    chk("en_wins_tap",  bus.tap_sel, 2);
    chk("en_wins_busy", bus.busy,    0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), $urandom());

`ifdef DELAY_SEQ_STATUS_EN
    // Many alternating switches saturate the counter.
    for (int i = 0; i < 300; i++) begin
      guard = 0;
      while (!m_rdy && guard < 10) begin
        step(1, 0, 2'd0, TAPS_FIX);
        guard++;
      end
      chk("ready_wait", bus.req_ready, 1);
      step(1, 1, (m_tap == 0) ? 2'd1 : 2'd0, TAPS_FIX);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, TAPS_FIX);
    chk("switch_sat", bus.switch_count, 32'd255);
`endif

    // Reset in the middle of a hold.
    guard = 0;
    while (!m_rdy && guard < 10) begin
      step(1, 0, 2'd0, TAPS_FIX);
      guard++;
    end
    chk("ready_wait2", bus.req_ready, 1);
    step(1, 1, (m_tap == 3) ? 2'd2 : 2'd3, TAPS_FIX);
    chk("mid_hold_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0; cyc = 0;
    for (int i = 0; i < 35; i++) step(1, 0, 2'd0, TAPS_FIX);
    chk("refill_data", bus.data_out, 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
